// File: rtl/sync_tx.sv
// J/K line transmitter: SYNC pattern, NRZI bit-stuffed payload (LSB first), SE0 end-of-packet.
// All line outputs are registered; data_ready is decoded from state only.
module sync_tx #(
  parameter int unsigned EOP_LEN   = 2,
  parameter int unsigned STUFF_LEN = 6
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic       k,
  output logic       j,
  output logic       tx_en,
  output logic       busy,
  output logic       underrun
);

  localparam int unsigned OW = $clog2(STUFF_LEN + 1);
  localparam int unsigned EW = (EOP_LEN > 1) ? $clog2(EOP_LEN) : 1;
  localparam logic [OW-1:0] StuffMax = OW'(STUFF_LEN);
  localparam logic [EW-1:0] EopMax   = EW'(EOP_LEN - 1);

  typedef enum logic [2:0] {StIdle, StSync, StData, StStuff, StEop} state_e;

  state_e        state_q;
  logic [2:0]    idx_q;
  logic [OW-1:0] ones_q;
  logic [EW-1:0] eop_cnt_q;
  logic [7:0]    byte_q;
  logic          last_q;
  logic          eop_pend_q;

  logic [2:0]    idx_inc;
  logic          emit_v;
  logic          sync_k;
  logic          stuff_now;
  logic [OW-1:0] ones_nxt;

  always_comb begin
    idx_inc    = idx_q + 3'd1;
    data_ready = ((state_q == StSync) && (idx_q == 3'd7)) ||
                 ((state_q == StData) && (idx_q == 3'd7) && !last_q);
    stuff_now  = (ones_q == StuffMax);
    // SYNC is K J K J K J K K: K on even indices and on the final one.
    sync_k     = (idx_inc == 3'd7) || !idx_inc[0];
    case (state_q)
      StSync:  emit_v = data_in[0];
      StData:  emit_v = (idx_q == 3'd7) ? data_in[0] : byte_q[idx_inc];
      StStuff: emit_v = byte_q[idx_inc];
      default: emit_v = 1'b0;
    endcase
    ones_nxt = emit_v ? ones_q + 1'b1 : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      ones_q     <= '0;
      eop_cnt_q  <= '0;
      byte_q     <= '0;
      last_q     <= 1'b0;
      eop_pend_q <= 1'b0;
      k          <= 1'b0;
      j          <= 1'b1;
      tx_en      <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (data_ready && data_valid) begin
        byte_q <= data_in;
        last_q <= data_last;
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StSync;
            idx_q   <= '0;
            ones_q  <= '0;
            k       <= 1'b1;
            j       <= 1'b0;
            tx_en   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        StSync: begin
          if (idx_q != 3'd7) begin
            idx_q <= idx_inc;
            k     <= sync_k;
            j     <= ~sync_k;
          end else if (data_valid) begin
            state_q <= StData;
            idx_q   <= idx_inc;
            k       <= k ^ ~emit_v;
            j       <= j ^ ~emit_v;
            ones_q  <= ones_nxt;
          end else begin
            underrun  <= 1'b1;
            state_q   <= StEop;
            eop_cnt_q <= '0;
            k         <= 1'b0;
            j         <= 1'b0;
          end
        end
        StData: begin
          if (data_ready && !data_valid) begin
            underrun  <= 1'b1;
            state_q   <= StEop;
            eop_cnt_q <= '0;
            k         <= 1'b0;
            j         <= 1'b0;
          end else if (stuff_now) begin
            // Bit index holds; eop_pend_q remembers whether bit 7 closed the packet.
            state_q    <= StStuff;
            eop_pend_q <= last_q;
            k          <= ~k;
            j          <= ~j;
            ones_q     <= '0;
          end else if ((idx_q == 3'd7) && last_q) begin
            state_q   <= StEop;
            eop_cnt_q <= '0;
            k         <= 1'b0;
            j         <= 1'b0;
          end else begin
            idx_q  <= idx_inc;
            k      <= k ^ ~emit_v;
            j      <= j ^ ~emit_v;
            ones_q <= ones_nxt;
          end
        end
        StStuff: begin
          if ((idx_q == 3'd7) && eop_pend_q) begin
            state_q   <= StEop;
            eop_cnt_q <= '0;
            k         <= 1'b0;
            j         <= 1'b0;
          end else begin
            state_q <= StData;
            idx_q   <= idx_inc;
            k       <= k ^ ~emit_v;
            j       <= j ^ ~emit_v;
            ones_q  <= ones_nxt;
          end
        end
        StEop: begin
          if (eop_cnt_q == EopMax) begin
            state_q <= StIdle;
            k       <= 1'b0;
            j       <= 1'b1;
            tx_en   <= 1'b0;
            busy    <= 1'b0;
          end else begin
            eop_cnt_q <= eop_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_tx.sv
// Scoreboard bench for sync_tx: a reference encoder queues the expected per-cycle line
// state when a packet is launched; the negedge monitor pops and compares while tx_en is high.
module tb_sync_tx;

  localparam int unsigned EopLen   = 2;
  localparam int unsigned StuffLen = 6;
  localparam logic [1:0]  SymJ     = 2'b01;
  localparam logic [1:0]  SymK     = 2'b10;
  localparam logic [1:0]  SymSe0   = 2'b00;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_last;
  logic       data_ready;
  logic       k;
  logic       j;
  logic       tx_en;
  logic       busy;
  logic       underrun;

  int n_checks = 0;
  int n_errors = 0;

  // Expected {data_ready, underrun, busy, k, j} for each tx_en cycle.
  logic [4:0] exp_q[$];
  logic [7:0] src_q[$];
  logic [4:0] mon_exp;
  int         src_ptr = 0;
  bit         src_last = 1'b0;
  bit         xfer = 1'b0;
  bit         mon_en = 1'b0;
  int         tx_len = 0;
  int         exp_len = 0;

  sync_tx #(
    .EOP_LEN  (EopLen),
    .STUFF_LEN(StuffLen)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_last (data_last),
    .data_ready(data_ready),
    .k         (k),
    .j         (j),
    .tx_en     (tx_en),
    .busy      (busy),
    .underrun  (underrun)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive_src();
    data_valid = (src_ptr < src_q.size());
    data_in    = data_valid ? src_q[src_ptr] : 8'h00;
    data_last  = data_valid && src_last && (src_ptr == src_q.size() - 1);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (xfer) src_ptr++;
    drive_src();
  endtask

  function automatic logic [1:0] flip(input logic [1:0] s);
    return (s == SymK) ? SymJ : SymK;
  endfunction

  // Reference encoder; a packet without the last flag ends in an underrun after src_q runs out.
  task automatic build_exp();
    logic [1:0] lvl;
    logic [7:0] b;
    int         ones;
    int         n;
    bit         fin;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({i == 7, 1'b0, 1'b1, ((i == 7) || (i % 2 == 0)) ? SymK : SymJ});
    end
    lvl  = SymK;
    ones = 0;
    n    = src_q.size();
    for (int bi = 0; bi < n; bi++) begin
      b   = src_q[bi];
      fin = (bi == n - 1);
      for (int i = 0; i < 8; i++) begin
        if (b[i]) begin
          ones++;
        end else begin
          ones = 0;
          lvl  = flip(lvl);
        end
        exp_q.push_back({(i == 7) && !(fin && src_last), 1'b0, 1'b1, lvl});
        if ((ones == StuffLen) && !(fin && (i == 7) && !src_last)) begin
          ones = 0;
          lvl  = flip(lvl);
          exp_q.push_back({1'b0, 1'b0, 1'b1, lvl});
        end
      end
    end
    for (int e = 0; e < EopLen; e++) begin
      exp_q.push_back({1'b0, !src_last && (e == 0), 1'b1, SymSe0});
    end
  endtask

  task automatic run_pkt(input bit last_flag, input int start_at);
    int t;
    src_last = last_flag;
    src_ptr  = 0;
    build_exp();
    exp_len = exp_q.size();
    drive_src();
    tx_len = 0;
    start  = 1'b1;
    step();
    start  = 1'b0;
    @(negedge CLK);
    check("tx_rise", 32'(tx_en), 32'd1);
    t = 0;
    while ((exp_q.size() != 0) && (t < 400)) begin
      step();
      start = (t == start_at);
      t++;
    end
    start = 1'b0;
    check("drain", 32'(exp_q.size()), 32'd0);
    check("tx_len", 32'(tx_len), 32'(exp_len));
    exp_q.delete();
  endtask

  always @(negedge CLK) begin
    xfer = data_ready && data_valid;
    if (mon_en) begin
      if (tx_en) begin
        tx_len++;
        if (exp_q.size() == 0) begin
          check("extra_sym", 32'(tx_en), 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("line", 32'({data_ready, underrun, busy, k, j}), 32'(mon_exp));
        end
      end else begin
        check("idle", 32'({data_ready, underrun, busy, k, j}), 32'(5'b00001));
      end
    end
  end

  initial begin
    RST   = 1'b1;
    start = 1'b0;
    drive_src();
    repeat (3) step();
    RST = 1'b0;
    @(negedge CLK);
    check("rst_state", 32'({k, j, tx_en, busy, data_ready, underrun}), 32'(6'b010000));
    step();
    mon_en = 1'b1;
    step();
    step();

    src_q = '{8'h00};
    run_pkt(1'b1, -1);
    src_q = '{8'hFF};
    run_pkt(1'b1, -1);
    src_q = '{8'hA5, 8'h3C};
    run_pkt(1'b1, -1);
    src_q = '{8'hFF};
    run_pkt(1'b0, -1);
    src_q.delete();
    run_pkt(1'b0, -1);
    src_q = '{8'hF0, 8'h0F};
    run_pkt(1'b1, 10);
    step();
    step();

    // Reset in the middle of a packet.
    src_q    = '{8'h55, 8'hC3};
    src_last = 1'b1;
    src_ptr  = 0;
    build_exp();
    drive_src();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    mon_en = 1'b0;
    RST    = 1'b1;
    repeat (3) step();
    RST = 1'b0;
    @(negedge CLK);
    check("rst_mid", 32'({k, j, tx_en, busy, data_ready, underrun}), 32'(6'b010000));
    exp_q.delete();
    src_q.delete();
    src_ptr = 0;
    drive_src();
    step();
    mon_en = 1'b1;
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
